// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing the single uart_top transmit path among NUM_REQ requesters.
// Define UART_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned BUSY_TIMEOUT = 8,
  localparam int unsigned ID_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [NUM_REQ-1:0]   req_i,
  input  logic [NUM_REQ*8-1:0] req_data_i,
  output logic [NUM_REQ-1:0]   grant_o,
  output logic [7:0]           tx_data_o,
  output logic                 tx_start_o,
  input  logic                 tx_busy_i,
  output logic [ID_W-1:0]      active_id_o,
  output logic                 arb_busy_o,
  output logic                 timeout_err_o
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [ID_W-1:0]      rr_ptr_q;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic                 tx_start_q, tx_start_d;
  logic [ID_W-1:0]      active_id_q, active_id_d;
  logic                 arb_busy_q;
  logic                 timeout_q, timeout_d;

  logic                 hi_vld;
  logic [ID_W-1:0]      hi_id;
  logic [ID_W-1:0]      lo_id;
  logic [ID_W-1:0]      win_id;
  logic [7:0]           win_byte;

  // Scan downwards so the last hit is the lowest index: overall and at/above rr_ptr.
  always_comb begin
    hi_vld = 1'b0;
    hi_id  = '0;
    lo_id  = '0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        lo_id = ID_W'(i);
        if (ID_W'(i) >= rr_ptr_q) begin
          hi_vld = 1'b1;
          hi_id  = ID_W'(i);
        end
      end
    end
  end

  assign win_id = hi_vld ? hi_id : lo_id;

  always_comb begin
    win_byte = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == win_id) win_byte = req_data_i[8*i +: 8];
    end
  end

`ifdef UART_ARB_FIXED_PRIO_EN
  // With the pointer pinned at 0 the search degenerates to lowest-index-wins.
  assign rr_ptr_q = '0;
`else
  logic [ID_W-1:0] rr_next;

  assign rr_next = (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + ID_W'(1);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rr_ptr_q <= '0;
    end else if (|grant_d) begin
      rr_ptr_q <= rr_next;
    end
  end
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    grant_d     = '0;
    tx_start_d  = 1'b0;
    timeout_d   = 1'b0;
    tx_data_d   = tx_data_q;
    active_id_d = active_id_q;
    unique case (state_q)
      IDLE: begin
        if (|req_i && !tx_busy_i) begin
          state_d     = WAIT_BUSY;
          cnt_d       = '0;
          grant_d     = NUM_REQ'(1) << win_id;
          tx_start_d  = 1'b1;
          tx_data_d   = win_byte;
          active_id_d = win_id;
        end
      end
      WAIT_BUSY: begin
        if (tx_busy_i) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == CNT_W'(BUSY_TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_DONE: begin
        if (!tx_busy_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      grant_q     <= '0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= '0;
      active_id_q <= '0;
      arb_busy_q  <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      grant_q     <= grant_d;
      tx_start_q  <= tx_start_d;
      tx_data_q   <= tx_data_d;
      active_id_q <= active_id_d;
      arb_busy_q  <= (state_d != IDLE);
      timeout_q   <= timeout_d;
    end
  end

  assign grant_o       = grant_q;
  assign tx_data_o     = tx_data_q;
  assign tx_start_o    = tx_start_q;
  assign active_id_o   = active_id_q;
  assign arb_busy_o    = arb_busy_q;
  assign timeout_err_o = timeout_q;

endmodule
